// File: rtl/trig_stretch.sv
// Trigger pulse stretcher: synchronized rising-edge detect, fixed-width output pulse, lockout, saturating counters.
// Optional retrigger-in-pulse behaviour is enabled by defining TRIG_STRETCH_RETRIG_EN.
module trig_stretch #(
  parameter int WIDTH_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic                  enable,
  input  logic [WIDTH_BITS-1:0] width_cfg,
  input  logic [WIDTH_BITS-1:0] lock_cfg,
  input  logic                  cnt_clr,
  output logic                  trig_out,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   trig_cnt,
  output logic [CNT_BITS-1:0]   miss_cnt
);

`ifdef TRIG_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} state_t;

  state_t                state, state_nx;
  logic                  sync1, sync2, edge_q;
  logic                  rise, accept;
  logic [WIDTH_BITS-1:0] cnt, cnt_nx, lock_q, lock_nx, width_eff;
  logic                  trig_inc, miss_inc;
  logic                  trig_nx, busy_nx;

  // Flops preload the input level in reset so a held-high input cannot look like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= sig_in;
      sync2  <= sig_in;
      edge_q <= sig_in;
    end else begin
      sync1  <= sig_in;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign rise      = sync2 & ~edge_q;
  assign accept    = rise & enable;
  assign width_eff = (width_cfg == '0) ? WIDTH_BITS'(1) : width_cfg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lock_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      lock_q <= lock_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lock_nx  = lock_q;
    trig_inc = 1'b0;
    miss_inc = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = PULSE;
          cnt_nx   = width_eff;
          lock_nx  = lock_cfg;
          trig_inc = 1'b1;
        end
      end
      PULSE: begin
        if (RETRIG && accept) begin
          cnt_nx   = width_eff;
          trig_inc = 1'b1;
        end else begin
          miss_inc = accept;
          if (cnt <= WIDTH_BITS'(1)) begin
            state_nx = (lock_q != '0) ? LOCKOUT : IDLE;
            cnt_nx   = lock_q;
          end else begin
            cnt_nx = cnt - WIDTH_BITS'(1);
          end
        end
      end
      LOCKOUT: begin
        miss_inc = accept;
        if (cnt <= WIDTH_BITS'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - WIDTH_BITS'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_comb begin
    trig_nx = (state_nx == PULSE);
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trig_out <= trig_nx;
      busy     <= busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      trig_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (trig_inc && (trig_cnt != '1)) trig_cnt <= trig_cnt + CNT_BITS'(1);
      if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_trig_stretch.sv
// Directed bench for trig_stretch with a time-based reference model checked every cycle.
module tb_trig_stretch;
  localparam int CB  = 4;
  localparam int SAT = (1 << CB) - 1;
`ifdef TRIG_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, sig_in, enable, cnt_clr;
  logic [7:0]    width_cfg, lock_cfg;
  logic          trig_out, busy;
  logic [CB-1:0] trig_cnt, miss_cnt;

  trig_stretch #(.WIDTH_BITS(8), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
    .width_cfg(width_cfg), .lock_cfg(lock_cfg), .cnt_clr(cnt_clr),
    .trig_out(trig_out), .busy(busy), .trig_cnt(trig_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks the cycle index where the pulse and the busy window end.
  int t = 0, pend = -100, bend = -100, mlock = 0, w = 0;
  int m_trig = 0, m_miss = 0;
  bit p1, p2, p3, rise, inc_t, inc_m;
  bit exp_trig = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    t++;
    if (reset) begin
      p1 = sig_in; p2 = sig_in; p3 = sig_in;
      pend = -100; bend = -100; m_trig = 0; m_miss = 0;
    end else begin
      rise = p2 && !p3;
      inc_t = 1'b0; inc_m = 1'b0;
      if (rise && enable) begin
        w = (width_cfg == 0) ? 1 : int'(width_cfg);
        if (t - 1 > bend) begin
          pend = t + w - 1; mlock = int'(lock_cfg); bend = pend + mlock; inc_t = 1'b1;
        end else if (RETRIG && (t - 1 <= pend)) begin
          pend = t + w - 1; bend = pend + mlock; inc_t = 1'b1;
        end else begin
          inc_m = 1'b1;
        end
      end
      if (cnt_clr) begin
        m_trig = 0; m_miss = 0;
      end else begin
        if (inc_t && m_trig < SAT) m_trig++;
        if (inc_m && m_miss < SAT) m_miss++;
      end
      p3 = p2; p2 = p1; p1 = sig_in;
    end
    exp_trig = (t <= pend);
    exp_busy = (t <= bend);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("trig_out", int'(trig_out), int'(exp_trig));
      chk("busy", int'(busy), int'(exp_busy));
      chk("trig_cnt", int'(trig_cnt), m_trig);
      chk("miss_cnt", int'(miss_cnt), m_miss);
    end
  end

  // Drives sig_in from pat (bit i before rising edge i+1); counts high cycles of outputs.
  task automatic drive(input logic [31:0] pat, input int n, output int hi, output int bz, output int first);
    hi = 0; bz = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      sig_in = (i < 32) ? pat[i] : 1'b0;
      @(negedge clk);
      if (trig_out) begin
        hi++;
        if (first < 0) first = i + 1;
      end
      if (busy) bz++;
    end
    sig_in = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  int hi, bz, first;

  initial begin
    reset = 1'b1; sig_in = 1'b0; enable = 1'b1; cnt_clr = 1'b0;
    width_cfg = 8'd5; lock_cfg = 8'd3;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset trig_out", int'(trig_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset trig_cnt", int'(trig_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    // single rise, width 5 lockout 3
    drive(32'b11, 20, hi, bz, first);
    chk("t1 first edge", first, 3);
    chk("t1 width", hi, 5);
    chk("t1 busy", bz, 8);
    chk("t1 trig_cnt", int'(trig_cnt), 1);
    chk("t1 miss_cnt", int'(miss_cnt), 0);
    clear_cnt();

    // second rise two cycles into the pulse
    drive(32'b101, 20, hi, bz, first);
    chk("t2 width", hi, RETRIG ? 7 : 5);
    chk("t2 busy", bz, RETRIG ? 10 : 8);
    chk("t2 trig_cnt", int'(trig_cnt), RETRIG ? 2 : 1);
    chk("t2 miss_cnt", int'(miss_cnt), RETRIG ? 0 : 1);
    clear_cnt();

    // zero width / zero lockout, rises every 4 cycles
    width_cfg = 8'd0; lock_cfg = 8'd0;
    drive(32'h0003_3333, 24, hi, bz, first);
    chk("t3 pulses", hi, 5);
    chk("t3 busy", bz, 5);
    chk("t3 trig_cnt", int'(trig_cnt), 5);
    chk("t3 miss_cnt", int'(miss_cnt), 0);

    // enable low: ignored
    enable = 1'b0;
    drive(32'b11, 10, hi, bz, first);
    enable = 1'b1;
    chk("t4 no pulse", hi, 0);
    chk("t4 trig_cnt", int'(trig_cnt), 5);
    chk("t4 miss_cnt", int'(miss_cnt), 0);

    // saturation after 16 triggers, then clear on an accepting cycle
    clear_cnt();
    drive(32'h3333_3333, 32, hi, bz, first);
    drive(32'h3333_3333, 32, hi, bz, first);
    chk("t5 saturated", int'(trig_cnt), 15);
    sig_in = 1'b1; @(negedge clk);
    sig_in = 1'b0; @(negedge clk);
    cnt_clr = 1'b1; @(negedge clk);
    cnt_clr = 1'b0;
    chk("t5 clr wins cnt", int'(trig_cnt), 0);
    chk("t5 clr pulse", int'(trig_out), 1);
    repeat (4) @(negedge clk);

    // input held high across reset release
    sig_in = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(32'hFFFF_FFFF, 10, hi, bz, first);
    chk("t6 held high", hi, 0);
    drive(32'h0, 4, hi, bz, first);

    // reset two cycles into a pulse
    width_cfg = 8'd5; lock_cfg = 8'd3;
    sig_in = 1'b1; @(negedge clk);
    @(negedge clk);
    sig_in = 1'b0; @(negedge clk);
    @(negedge clk);
    chk("t6 pulse live", int'(trig_out), 1);
    reset = 1'b1; @(negedge clk);
    chk("t6 rst trig_out", int'(trig_out), 0);
    chk("t6 rst busy", int'(busy), 0);
    chk("t6 rst trig_cnt", int'(trig_cnt), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trig_stretch.md
TRIG_STRETCH -- requirements
Module: trig_stretch

Interface
REQ-001 Parameter WIDTH_BITS, default 8, width of pulse-width and lockout configuration fields.
REQ-002 Parameter CNT_BITS, default 16, width of trigger and miss counters.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 SIG_IN  input  1  asynchronous output of upstream op-amp buffer stage; level to be discriminated.
REQ-006 ENABLE  input  1  high = new rising edges accepted.
REQ-007 WIDTH_CFG  input  WIDTH_BITS  output pulse width in CLK cycles.
REQ-008 LOCK_CFG  input  WIDTH_BITS  dead time after pulse in CLK cycles.
REQ-009 CNT_CLR  input  1  synchronous clear of both counters.
REQ-010 TRIG_OUT  output  1  stretched trigger pulse, registered.
REQ-011 BUSY  output  1  high in PULSE or LOCKOUT state, registered.
REQ-012 TRIG_CNT  output  CNT_BITS  accepted-trigger count, saturating.
REQ-013 MISS_CNT  output  CNT_BITS  rejected-edge count, saturating.

Function
REQ-014 SIG_IN SHALL pass a two-flop synchronizer then an edge flop; edge = sync2 high and edge flop low.
REQ-015 States SHALL be IDLE, PULSE, LOCKOUT; encoding free.
REQ-016 IDLE + edge + ENABLE high -> PULSE; width counter loads WIDTH_CFG (0 treated as 1), lockout value latches LOCK_CFG, TRIG_CNT increments.
REQ-017 TRIG_OUT SHALL rise on the 3rd rising CLK edge counting the first edge at which SIG_IN is sampled high.
REQ-018 TRIG_OUT SHALL be high for exactly the latched width in cycles; WIDTH_CFG/LOCK_CFG changes mid-pulse have no effect.
REQ-019 PULSE, width counter expiring -> LOCKOUT if latched lockout nonzero, else IDLE.
REQ-020 LOCKOUT SHALL last exactly the latched lockout cycles, then IDLE; an edge on the IDLE-return cycle is not accepted until IDLE is registered.
REQ-021 Edge in PULSE or LOCKOUT with ENABLE high SHALL increment MISS_CNT (unless REQ-030 applies).
REQ-022 Edges with ENABLE low SHALL be ignored and not counted; a pulse in progress completes normally.
REQ-023 Counters SHALL saturate at all-ones and hold.
REQ-024 CNT_CLR SHALL zero both counters next cycle; clear wins over a simultaneous increment.
REQ-025 BUSY SHALL equal (state != IDLE) registered, aligned with TRIG_OUT rise.
REQ-026 SIG_IN high shorter than one CLK period MAY be missed; no pulse-catch logic.

Reset
REQ-027 RESET SHALL force IDLE, TRIG_OUT=0, BUSY=0, TRIG_CNT=0, MISS_CNT=0, internal counters 0.
REQ-028 During RESET, sync1, sync2 and edge flop SHALL load SIG_IN, so SIG_IN held high across reset release produces no trigger.
REQ-029 RESET asserted mid-pulse SHALL drop TRIG_OUT on the next edge; no partial counts retained.

Configuration
REQ-030 Macro TRIG_STRETCH_RETRIG_EN defined: edge in PULSE with ENABLE high reloads width counter from current WIDTH_CFG (0 as 1), increments TRIG_CNT, not MISS_CNT; edges in LOCKOUT still count as miss.
REQ-031 Macro undefined: edges in PULSE count as miss per REQ-021; pulse width never extended.

Verification
REQ-032 WIDTH_CFG=5, LOCK_CFG=3, single SIG_IN rise -> TRIG_OUT high 5 cycles starting 3rd edge, BUSY high 8 cycles, TRIG_CNT=1, MISS_CNT=0.
REQ-033 Same config, second rise 2 cycles into pulse (macro off) -> width 5 unchanged, TRIG_CNT=1, MISS_CNT=1; macro on -> TRIG_OUT high 7 cycles, TRIG_CNT=2, MISS_CNT=0.
REQ-034 WIDTH_CFG=0, LOCK_CFG=0, rises every 4 cycles -> 1-cycle pulses each, no misses, TRIG_CNT counts all.
REQ-035 CNT_BITS=4, 16 accepted triggers -> TRIG_CNT stays 15; CNT_CLR on an accepting cycle -> TRIG_CNT=0.
REQ-036 SIG_IN high throughout RESET, released -> no TRIG_OUT; RESET asserted 2 cycles into pulse -> TRIG_OUT=0 next edge, counters 0.
REQ-037 ENABLE low during rise -> no pulse, both counters unchanged.
